// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, one-at-a-time handshaked imem requests, prefetch FIFO.
// Optional `IFU_STALL_CNT_EN adds a saturating 16-bit stall_cnt output (empty-with-ready cycles).
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [23:0] RESET_PC = 24'd10
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic        imem_req,
   output logic [23:0] imem_addr,
   input  logic        imem_ack,
   input  logic [23:0] imem_rdata,
   input  logic        redirect,
   input  logic [23:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [23:0] inst,
   output logic [23:0] inst_pc,
   output logic [3:0]  opcode
`ifdef IFU_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_req;
   logic [23:0]        r_fetch_pc;
   logic [23:0]        r_target;
   logic [CNT_W-1:0]   r_cnt;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [23:0]        r_pc_mem   [DEPTH];
   logic [23:0]        r_word_mem [DEPTH];

   state_t             w_state_nxt;
   logic [23:0]        w_fetch_pc_nxt;
   logic [23:0]        w_target_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_ack;
   logic               w_push;
   logic               w_pop;

   // r_req is low in HOLD and in the first cycle out of reset, so stray acks there are ignored
   assign w_ack  = imem_ack && r_req;
   assign w_push = w_ack && (r_state == S_FETCH) && !redirect;
   assign w_pop  = inst_valid && inst_ready;

   // Occupancy after this edge; redirect empties the buffer regardless of push/pop
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (redirect) begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Next-state logic; a pending request is never abandoned, so redirect without ack drains it
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_target_nxt   = r_target;
      if (redirect) begin
         case (r_state)
            S_FETCH: begin
               if (w_ack || !r_req) begin
                  w_state_nxt    = S_FETCH;
                  w_fetch_pc_nxt = redirect_pc;
               end else begin
                  w_state_nxt  = S_DRAIN;
                  w_target_nxt = redirect_pc;
               end
            end
            S_DRAIN: begin
               if (w_ack) begin
                  w_state_nxt    = S_FETCH;
                  w_fetch_pc_nxt = redirect_pc;
               end else begin
                  w_state_nxt  = S_DRAIN;
                  w_target_nxt = redirect_pc;
               end
            end
            S_HOLD: begin
               w_state_nxt    = S_FETCH;
               w_fetch_pc_nxt = redirect_pc;
            end
            default: begin
               w_state_nxt    = S_FETCH;
               w_fetch_pc_nxt = redirect_pc;
            end
         endcase
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_ack) begin
                  w_fetch_pc_nxt = r_fetch_pc + 24'd3;
                  w_state_nxt    = (w_cnt_nxt < CNT_FULL) ? S_FETCH : S_HOLD;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end
            S_HOLD: begin
               w_state_nxt = (w_cnt_nxt < CNT_FULL) ? S_FETCH : S_HOLD;
            end
            S_DRAIN: begin
               if (w_ack) begin
                  w_state_nxt    = S_FETCH;
                  w_fetch_pc_nxt = r_target;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end
            default: begin
               w_state_nxt = S_FETCH;
            end
         endcase
      end
   end

   // Control state, PC and FIFO pointers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= S_FETCH;
         r_req      <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_target   <= RESET_PC;
         r_cnt      <= {CNT_W{1'b0}};
         r_wr_ptr   <= {PTR_W{1'b0}};
         r_rd_ptr   <= {PTR_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= (w_state_nxt != S_HOLD);
         r_fetch_pc <= w_fetch_pc_nxt;
         r_target   <= w_target_nxt;
         r_cnt      <= w_cnt_nxt;
         if (redirect) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
         end
      end
   end

   // FIFO storage; contents are don't-care until counted valid
   always_ff @(posedge Clock) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
         r_word_mem[r_wr_ptr] <= imem_rdata;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_fetch_pc;
   assign inst_valid = (r_cnt != {CNT_W{1'b0}});
   assign inst       = inst_valid ? r_word_mem[r_rd_ptr] : 24'd0;
   assign inst_pc    = inst_valid ? r_pc_mem[r_rd_ptr]   : 24'd0;
   assign opcode     = inst[23:20];

`ifdef IFU_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of cycles where the consumer is ready but nothing is buffered
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_stall_cnt <= 16'd0;
      end else if (!inst_valid && inst_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit; memory returns word(addr) = {addr[3:0], addr[19:0]}.
module tb_instr_fetch_unit;

   logic        Clock;
   logic        Reset;
   logic        imem_req;
   logic [23:0] imem_addr;
   logic        imem_ack;
   logic [23:0] imem_rdata;
   logic        redirect;
   logic [23:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [23:0] inst;
   logic [23:0] inst_pc;
   logic [3:0]  opcode;
`ifdef IFU_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_vec;
   int n_miss;
   int stall_exp;

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(24'd10)) u_dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .opcode      (opcode)
`ifdef IFU_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [23:0] word(input logic [23:0] a);
      return {a[3:0], a[19:0]};
   endfunction

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 24'd0;
      redirect   = 1'b0;
      inst_ready = 1'b0;
      tick();
      chk_vec("rst.req",   {31'd0, imem_req},   32'd0);
      chk_vec("rst.addr",  {8'd0, imem_addr},   32'd10);
      chk_vec("rst.valid", {31'd0, inst_valid}, 32'd0);
      chk_vec("rst.inst",  {8'd0, inst},        32'd0);
      chk_vec("rst.pc",    {8'd0, inst_pc},     32'd0);
      stall_exp = 0;
      Reset = 1'b0;
      tick();
   endtask

   // Check this cycle's outputs, then drive this cycle's inputs and advance one clock
   task automatic vec(input string tag, input logic e_req, input logic [23:0] e_addr,
                      input logic e_val, input logic [23:0] e_pc,
                      input logic a_ack, input logic a_rdy,
                      input logic a_red, input logic [23:0] a_rpc);
      logic [23:0] e_inst;
      e_inst = word(e_pc);
      chk_vec({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) chk_vec({tag, ".addr"}, {8'd0, imem_addr}, {8'd0, e_addr});
      chk_vec({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, e_val});
      if (e_val) begin
         chk_vec({tag, ".pc"},   {8'd0, inst_pc},  {8'd0, e_pc});
         chk_vec({tag, ".inst"}, {8'd0, inst},     {8'd0, e_inst});
         chk_vec({tag, ".opc"},  {28'd0, opcode},  {28'd0, e_inst[23:20]});
      end
      if (!e_val && a_rdy) stall_exp = stall_exp + 1;
      imem_ack    = a_ack;
      imem_rdata  = a_ack ? word(e_addr) : 24'd0;
      inst_ready  = a_rdy;
      redirect    = a_red;
      redirect_pc = a_rpc;
      tick();
   endtask

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      stall_exp   = 0;
      Reset       = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 24'd0;
      redirect    = 1'b0;
      redirect_pc = 24'd0;
      inst_ready  = 1'b0;
      do_reset();

      // Streaming: same-cycle ack, consumer always ready
      vec("s1", 1'b1, 24'd10, 1'b0, 24'd0,  1'b1, 1'b1, 1'b0, 24'd0);
      vec("s2", 1'b1, 24'd13, 1'b1, 24'd10, 1'b1, 1'b1, 1'b0, 24'd0);
      vec("s3", 1'b1, 24'd16, 1'b1, 24'd13, 1'b1, 1'b1, 1'b0, 24'd0);
      vec("s4", 1'b1, 24'd19, 1'b1, 24'd16, 1'b1, 1'b1, 1'b0, 24'd0);
      vec("s5", 1'b1, 24'd22, 1'b1, 24'd19, 1'b0, 1'b1, 1'b0, 24'd0);

      // Reset with a request to 22 outstanding
      do_reset();

      // Fill to DEPTH with consumer stalled, stray ack in HOLD, then drain with delayed ack
      vec("f1",  1'b1, 24'd10, 1'b0, 24'd0,  1'b1, 1'b0, 1'b0, 24'd0);
      vec("f2",  1'b1, 24'd13, 1'b1, 24'd10, 1'b1, 1'b0, 1'b0, 24'd0);
      vec("f3",  1'b1, 24'd16, 1'b1, 24'd10, 1'b1, 1'b0, 1'b0, 24'd0);
      vec("f4",  1'b1, 24'd19, 1'b1, 24'd10, 1'b1, 1'b0, 1'b0, 24'd0);
      vec("f5",  1'b0, 24'd22, 1'b1, 24'd10, 1'b1, 1'b0, 1'b0, 24'd0);
      vec("f6",  1'b0, 24'd22, 1'b1, 24'd10, 1'b0, 1'b1, 1'b0, 24'd0);
      vec("f7",  1'b1, 24'd22, 1'b1, 24'd13, 1'b0, 1'b1, 1'b0, 24'd0);
      vec("f8",  1'b1, 24'd22, 1'b1, 24'd16, 1'b0, 1'b1, 1'b0, 24'd0);
      vec("f9",  1'b1, 24'd22, 1'b1, 24'd19, 1'b0, 1'b1, 1'b0, 24'd0);
      vec("f10", 1'b1, 24'd22, 1'b0, 24'd0,  1'b1, 1'b0, 1'b0, 24'd0);
      vec("f11", 1'b1, 24'd25, 1'b1, 24'd22, 1'b0, 1'b0, 1'b0, 24'd0);
      vec("f12", 1'b1, 24'd25, 1'b1, 24'd22, 1'b0, 1'b1, 1'b0, 24'd0);

      // Redirect with request outstanding -> drain the ack for 25
      vec("d1", 1'b1, 24'd25,     1'b0, 24'd0,     1'b0, 1'b1, 1'b1, 24'h000100);
      vec("d2", 1'b1, 24'd25,     1'b0, 24'd0,     1'b0, 1'b1, 1'b0, 24'd0);
      vec("d3", 1'b1, 24'd25,     1'b0, 24'd0,     1'b1, 1'b1, 1'b0, 24'd0);
      vec("d4", 1'b1, 24'h000100, 1'b0, 24'd0,     1'b1, 1'b0, 1'b0, 24'd0);

      // Redirect coincident with ack and pop; target wraps through 0xFFFFFF
      vec("w1", 1'b1, 24'h000103, 1'b1, 24'h000100, 1'b1, 1'b1, 1'b1, 24'hFFFFFD);
      vec("w2", 1'b1, 24'hFFFFFD, 1'b0, 24'd0,      1'b1, 1'b1, 1'b0, 24'd0);
      vec("w3", 1'b1, 24'h000000, 1'b1, 24'hFFFFFD, 1'b1, 1'b1, 1'b0, 24'd0);
      vec("w4", 1'b1, 24'h000003, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 24'd0);
      vec("w5", 1'b1, 24'h000006, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 24'd0);
      vec("w6", 1'b1, 24'h000009, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 24'd0);

      // Redirect while in HOLD
      vec("h1", 1'b0, 24'd0,      1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000200);
      vec("h2", 1'b1, 24'h000200, 1'b0, 24'd0,      1'b0, 1'b1, 1'b0, 24'd0);

`ifdef IFU_STALL_CNT_EN
      chk_vec("stall_cnt", {16'd0, stall_cnt}, stall_exp);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the 24-bit single-cycle CPU. It owns the program counter, issues one-at-a-time requests to a handshaked instruction memory, and buffers fetched words in a small prefetch FIFO. It presents them to the datapath/decode stage through a valid/ready interface, together with each word's PC and its 4-bit opcode field. Branch and jump targets computed downstream come back as a redirect, which flushes the buffer and restarts fetch.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `RESET_PC`, 24'd10: first fetch address after reset.

Ports:
- `Clock` in 1: single clock, all state on rising edge.
- `Reset` in 1: synchronous, active-high.
- `imem_req` out 1: fetch request; held high with `imem_addr` stable until `imem_ack`.
- `imem_addr` out 24: fetch byte address.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 24: fetched instruction word.
- `redirect` in 1: one-cycle pulse; discard buffered/in-flight work and fetch from `redirect_pc`.
- `redirect_pc` in 24: new fetch address, sampled when `redirect`=1.
- `inst_valid` out 1: FIFO head valid.
- `inst_ready` in 1: consumer accepts head when `inst_valid`&&`inst_ready`.
- `inst` out 24: head instruction word.
- `inst_pc` out 24: address the head word was fetched from.
- `opcode` out 4: `inst[23:20]`, combinational from head.

## Operation
- FIFO: `DEPTH` entries of {pc, word}; circular read/write pointers plus occupancy count `cnt` (0..DEPTH).
- `fetch_pc`: next address; +3 per accepted ack, modulo 2^24 (0xFFFFFD+3 → 0x000000).
- FSM:
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`. On ack, push {fetch_pc, imem_rdata}, `fetch_pc`+=3. Stay in FETCH if post-edge `cnt` < DEPTH, else go to HOLD.
  - HOLD: `imem_req`=0. Go to FETCH the cycle after `cnt` drops below DEPTH.
  - DRAIN: entered on redirect while a request is outstanding without ack. Keep `imem_req`=1 and the old address. On ack, discard data and go to FETCH at the latched target.
- Slot reservation: a request is only issued when a free slot exists, so every ack can be pushed. Push and pop in the same cycle is always legal, including when full.
- Redirect, highest priority:
  - FIFO cleared (`cnt`=0) at the edge; `fetch_pc`←`redirect_pc`.
  - A handshake in the same cycle still completes; the consumer keeps that word.
  - Redirect coincident with ack: data discarded, go to FETCH, no drain.
  - Redirect in FETCH without ack: go to DRAIN.
  - Redirect in DRAIN: target overwritten, stay in DRAIN.
  - Redirect in HOLD: go to FETCH.
- An ack arriving in HOLD is a protocol error; ignore it (no push).

## Timing
- Reset values (during and at the edge leaving reset): `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `cnt`=0, state FETCH.
- First cycle after `Reset` deasserts: `imem_req`=1, `imem_addr`=RESET_PC.
- Ack in cycle N → `inst_valid`=1 in N+1 (one-cycle fill latency). A new request (`fetch_pc`+3) is already presented in N+1.
- Throughput: one instruction per cycle with same-cycle ack and `inst_ready` held high.
- Redirect in cycle N:
  - `inst_valid`=0 in N+1.
  - If no drain: `imem_req`=1, `imem_addr`=`redirect_pc` in N+1.
  - If drained: request is presented the cycle after the draining ack.
- Reset mid-operation: all state returns to reset values at that edge. An outstanding request is abandoned; the memory must drop it on `Reset`.

## Configuration
- `IFU_STALL_CNT_EN` defined: adds output `stall_cnt` (16 bits).
  - Reset to 0.
  - Increments each non-reset cycle with `inst_valid`=0 && `inst_ready`=1.
  - Saturates at 0xFFFF; is not cleared by redirect.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, memory acks every request in the same cycle, `inst_ready`=1 → requests to 10, 13, 16, 19. `inst_pc` sequence 10, 13, 16… one per cycle from cycle 2; `opcode`=`imem_rdata[23:20]`.
- `inst_ready`=0 with DEPTH=4 → exactly 4 words buffered, then `imem_req`=0. Raise `inst_ready` → words 10..19 delivered in order, and `imem_req` reasserts at address 22 one cycle after the first pop.
- Ack delayed 3 cycles → `imem_addr` stable and `imem_req` high for all 3 cycles. No duplicate push.
- Redirect to 0x000100 while a request to 22 is outstanding → ack for 22 discarded, next request to 0x000100, and the first word out after the redirect has `inst_pc`=0x000100.
- Redirect coincident with ack and with a pop of head 10 → consumer gets 10, the ack word is dropped, next cycle `imem_addr`=`redirect_pc` and `inst_valid`=0.
- `redirect_pc`=0xFFFFFD → subsequent fetch addresses 0xFFFFFD, 0x000000, 0x000003. With `IFU_STALL_CNT_EN`, `stall_cnt` equals the number of empty-with-ready cycles observed.
